// File: rtl/sseg4_scan.sv
// Refresh controller for a 4-digit seven-segment display. Scans the digits,
// blanks the anodes at the start of every slot, and snapshots the value once per frame.
module sseg4_scan #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] data_in,
  input  logic        hex_dec_in,
  input  logic        sign_in,
  input  logic        hold,
  input  logic [3:0]  an_in,
  output logic [15:0] data,
  output logic        hex_dec,
  output logic        sign,
  output logic [1:0]  digit_sel,
  output logic [3:0]  an,
  output logic        frame_start
);

  localparam int            CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    r_digit_sel;
  logic          r_frame_start;
  logic [15:0]   r_data;
  logic          r_hex_dec;
  logic          r_sign;
  logic          w_wrap;
  logic          w_frame_nxt;
  logic          w_blank_nxt;

  assign w_wrap      = (r_cnt == CNT_LAST);
  assign w_cnt_nxt   = w_wrap ? '0 : r_cnt + CW'(1);
  assign w_frame_nxt = w_wrap && (r_digit_sel == 2'd3);

  // The phase is decided from the next count so show stays aligned with cnt.
  generate
    if (BLANK_CYCLES == 0) begin : g_noblank
      assign w_blank_nxt = 1'b0;
    end else begin : g_blank
      localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);
      assign w_blank_nxt = (w_cnt_nxt < BLANK_LIM);
    end
  endgenerate

  always_comb begin
    w_state_nxt = ST_BLANK;
    if (!w_blank_nxt) begin
      w_state_nxt = ST_SHOW;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_BLANK;
      r_cnt         <= '0;
      r_digit_sel   <= 2'd0;
      r_frame_start <= 1'b0;
      r_data        <= 16'h0000;
      r_hex_dec     <= 1'b0;
      r_sign        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_frame_start <= w_frame_nxt;
      if (w_wrap) begin
        r_digit_sel <= r_digit_sel + 2'd1;
      end
      if (w_frame_nxt && !hold) begin
        r_data    <= data_in;
        r_hex_dec <= hex_dec_in;
        r_sign    <= sign_in;
      end
    end
  end

  // Anode gate is combinational so it tracks sseg4's segment timing exactly.
  assign an          = (r_state == ST_SHOW) ? an_in : 4'b1111;
  assign digit_sel   = r_digit_sel;
  assign frame_start = r_frame_start;
  assign data        = r_data;
  assign hex_dec     = r_hex_dec;
  assign sign        = r_sign;

endmodule

// File: tb/tb_sseg4_scan.sv
// Bench for sseg4_scan: a blanking instance (DIV=8, BLANK=2) and a no-blank instance,
// checked each cycle against a time-index reference model.
module tb_sseg4_scan;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] data_in;
  logic        hex_dec_in;
  logic        sign_in;
  logic        hold;
  logic [3:0]  an_in, an_in0;
  logic [15:0] data, data0;
  logic        hex_dec, hex_dec0, sign, sign0;
  logic [1:0]  digit_sel, digit_sel0;
  logic [3:0]  an, an0;
  logic        frame_start, frame_start0;

  int          n_pass  = 0;
  int          n_total = 0;
  int          t;
  logic [15:0] m_data;
  logic        m_hd, m_sign;

  always #5 clk = ~clk;

  assign an_in  = ~(4'b0001 << digit_sel);
  assign an_in0 = ~(4'b0001 << digit_sel0);

  sseg4_scan #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .hex_dec_in(hex_dec_in),
    .sign_in(sign_in), .hold(hold), .an_in(an_in), .data(data), .hex_dec(hex_dec),
    .sign(sign), .digit_sel(digit_sel), .an(an), .frame_start(frame_start)
  );

  sseg4_scan #(.REFRESH_DIV(8), .BLANK_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .hex_dec_in(hex_dec_in),
    .sign_in(sign_in), .hold(hold), .an_in(an_in0), .data(data0), .hex_dec(hex_dec0),
    .sign(sign0), .digit_sel(digit_sel0), .an(an0), .frame_start(frame_start0)
  );

  // Expected anodes at cycle tt: 8-cycle slots, digits 0..3 in turn, first `blank` cycles dark.
  function automatic logic [3:0] exp_an(input int tt, input int blank);
    if ((tt % 8) < blank) return 4'b1111;
    return ~(4'b0001 << ((tt / 8) % 4));
  endfunction

  function automatic logic [1:0] exp_dsel(input int tt);
    return 2'((tt / 8) % 4);
  endfunction

  // One clock; the model loads the snapshot at each frame boundary when hold is low.
  task automatic step();
    @(posedge clk);
    t++;
    if (t % 32 == 0 && !hold) begin
      m_data = data_in;
      m_hd   = hex_dec_in;
      m_sign = sign_in;
    end
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    t = 0;
    m_data = 16'h0000; m_hd = 1'b0; m_sign = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; hold = 1'b0;
    data_in = 16'h1234; hex_dec_in = 1'b1; sign_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (an !== 4'b1111) $display("FAIL reset_an got %b want 1111", an); else n_pass++;
    n_total++; if (an0 !== 4'b1111) $display("FAIL reset_an0 got %b want 1111", an0); else n_pass++;
    n_total++; if (digit_sel !== 2'd0) $display("FAIL reset_dsel got %0d want 0", digit_sel); else n_pass++;
    n_total++; if ({data, hex_dec, sign} !== 18'h0)
      $display("FAIL reset_snap got %h/%b/%b want 0000/0/0", data, hex_dec, sign); else n_pass++;
    n_total++; if (frame_start !== 1'b0) $display("FAIL reset_fs got %b want 0", frame_start); else n_pass++;
    release_reset();
    for (int i = 0; i < 3; i++) begin
      n_total++; if (an !== exp_an(t, 2)) $display("FAIL release_an t=%0d got %b want %b", t, an, exp_an(t, 2)); else n_pass++;
      n_total++; if (frame_start !== 1'b0) $display("FAIL release_fs t=%0d got %b want 0", t, frame_start); else n_pass++;
      if (i < 2) step();
    end
  endtask

  task automatic test_scan();
    for (int i = 0; i < 40; i++) begin
      data_in = 16'($urandom); hex_dec_in = 1'($urandom); sign_in = 1'($urandom);
      step();
      n_total++; if (digit_sel !== exp_dsel(t)) $display("FAIL scan_dsel t=%0d got %0d want %0d", t, digit_sel, exp_dsel(t)); else n_pass++;
      n_total++; if (an !== exp_an(t, 2)) $display("FAIL scan_an t=%0d got %b want %b", t, an, exp_an(t, 2)); else n_pass++;
      n_total++; if (frame_start !== (t % 32 == 0)) $display("FAIL scan_fs t=%0d got %b want %b", t, frame_start, (t % 32 == 0)); else n_pass++;
      n_total++; if ({data, hex_dec, sign} !== {m_data, m_hd, m_sign})
        $display("FAIL scan_snap t=%0d got %h/%b/%b want %h/%b/%b", t, data, hex_dec, sign, m_data, m_hd, m_sign); else n_pass++;
    end
  endtask

  task automatic test_snapshot();
    data_in = 16'h0ABC; hex_dec_in = 1'b1; sign_in = 1'b0; hold = 1'b0;
    step();
    while (t % 32 != 0) begin
      n_total++; if (data !== m_data) $display("FAIL snap_pre t=%0d got %h want %h", t, data, m_data); else n_pass++;
      step();
    end
    n_total++; if (data !== 16'h0ABC || hex_dec !== 1'b1)
      $display("FAIL snap_load t=%0d got %h/%b want 0abc/1", t, data, hex_dec); else n_pass++;
    repeat (8) step();
    data_in = 16'h0123; hex_dec_in = 1'b0;
    while (t % 32 != 0) begin
      n_total++; if (data !== 16'h0ABC) $display("FAIL snap_mid t=%0d got %h want 0abc", t, data); else n_pass++;
      step();
    end
    n_total++; if (data !== 16'h0123 || hex_dec !== 1'b0)
      $display("FAIL snap_reload t=%0d got %h/%b want 0123/0", t, data, hex_dec); else n_pass++;
  endtask

  task automatic test_hold();
    logic [15:0] saved;
    saved = m_data;
    hold = 1'b1; data_in = 16'h0FFF;
    for (int i = 0; i < 64; i++) begin
      step();
      if (t % 32 == 0) begin
        n_total++; if (frame_start !== 1'b1) $display("FAIL hold_fs t=%0d got %b want 1", t, frame_start); else n_pass++;
        n_total++; if (data !== saved) $display("FAIL hold_data t=%0d got %h want %h", t, data, saved); else n_pass++;
      end
    end
    for (int i = 0; i < 96; i++) begin
      hold = 1'($urandom); data_in = 16'($urandom); sign_in = 1'($urandom);
      step();
      n_total++; if ({data, hex_dec, sign} !== {m_data, m_hd, m_sign})
        $display("FAIL hold_rand t=%0d got %h/%b/%b want %h/%b/%b", t, data, hex_dec, sign, m_data, m_hd, m_sign); else n_pass++;
    end
    hold = 1'b0;
  endtask

  task automatic test_reset_mid();
    while (!(exp_dsel(t) == 2'd2 && (t % 8) >= 2)) step();
    n_total++; if (an !== 4'b1011) $display("FAIL mid_pre_an got %b want 1011", an); else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_total++; if (an !== 4'b1111) $display("FAIL mid_async_an got %b want 1111", an); else n_pass++;
    n_total++; if (digit_sel !== 2'd0) $display("FAIL mid_async_dsel got %0d want 0", digit_sel); else n_pass++;
    n_total++; if (data !== 16'h0000) $display("FAIL mid_async_data got %h want 0000", data); else n_pass++;
    release_reset();
    for (int i = 0; i < 40; i++) begin
      n_total++; if (an !== exp_an(t, 2)) $display("FAIL mid_restart_an t=%0d got %b want %b", t, an, exp_an(t, 2)); else n_pass++;
      n_total++; if (digit_sel !== exp_dsel(t)) $display("FAIL mid_restart_dsel t=%0d got %0d want %0d", t, digit_sel, exp_dsel(t)); else n_pass++;
      step();
    end
  endtask

  task automatic test_noblank();
    for (int i = 0; i < 40; i++) begin
      data_in = 16'($urandom);
      step();
      n_total++; if (an0 !== exp_an(t, 0) || an0 === 4'b1111)
        $display("FAIL noblank_an t=%0d got %b want %b", t, an0, exp_an(t, 0)); else n_pass++;
      n_total++; if (data0 !== m_data) $display("FAIL noblank_data t=%0d got %h want %h", t, data0, m_data); else n_pass++;
    end
  endtask

  initial begin
    t = 0;
    m_data = 16'h0000; m_hd = 1'b0; m_sign = 1'b0;
    test_reset();
    test_scan();
    test_snapshot();
    test_hold();
    test_reset_mid();
    test_noblank();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
